// File: rtl/phy_urx.sv
// UART 8N1 receiver at 115200 baud. Bit timing comes from a 1 us strobe, and each bit is decided by a 3-sample majority vote.
// Outputs rx_vld or rx_err about 84 us after the start edge. There is no backpressure: every decided frame pulses exactly once.
module phy_urx (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       pluse_us,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_vld,
  output logic       rx_err
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t      state_q, state_d;
  logic        sync1_q, sync1_d;
  logic        rx_s_q, rx_s_d;
  logic        rx_prev_q, rx_prev_d;
  logic [7:0]  cnt_us_q, cnt_us_d;
  logic [2:0]  maj_sh_q, maj_sh_d;
  logic [7:0]  byte_q, byte_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_vld_q, rx_vld_d;
  logic        rx_err_q, rx_err_d;

  logic [2:0]  smp;
  logic        maj;

  // Decision tick for data bit i is its centre tick plus one.
  function automatic logic [7:0] dec_tick(input logic [2:0] idx);
    case (idx)
      3'd0:    dec_tick = 8'd15;
      3'd1:    dec_tick = 8'd24;
      3'd2:    dec_tick = 8'd32;
      3'd3:    dec_tick = 8'd41;
      3'd4:    dec_tick = 8'd50;
      3'd5:    dec_tick = 8'd58;
      3'd6:    dec_tick = 8'd67;
      default: dec_tick = 8'd76;
    endcase
  endfunction

  assign smp = {maj_sh_q[1:0], rx_s_q};
  assign maj = (smp[2] & smp[1]) | (smp[2] & smp[0]) | (smp[1] & smp[0]);

  always_comb begin
    state_d   = state_q;
    sync1_d   = uart_rx;
    rx_s_d    = sync1_q;
    rx_prev_d = rx_s_q;
    cnt_us_d  = cnt_us_q;
    maj_sh_d  = maj_sh_q;
    byte_d    = byte_q;
    bit_idx_d = bit_idx_q;
    rx_data_d = rx_data_q;
    rx_vld_d  = 1'b0;
    rx_err_d  = 1'b0;

    if (pluse_us && state_q != IDLE) maj_sh_d = smp;

    case (state_q)
      IDLE: begin
        if (rx_prev_q && !rx_s_q) begin
          cnt_us_d = 8'd1;
          state_d  = START;
        end
      end
      START: begin
        if (pluse_us) begin
          cnt_us_d = cnt_us_q + 8'd1;
          if (cnt_us_q == 8'd6) begin
            if (maj) begin
              cnt_us_d = 8'd0;
              state_d  = IDLE;
            end else begin
              bit_idx_d = 3'd0;
              state_d   = DATA;
            end
          end
        end
      end
      DATA: begin
        if (pluse_us) begin
          cnt_us_d = cnt_us_q + 8'd1;
          if (cnt_us_q == dec_tick(bit_idx_q)) begin
            byte_d    = {maj, byte_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_d = STOP;
          end
        end
      end
      STOP: begin
        if (pluse_us) begin
          cnt_us_d = cnt_us_q + 8'd1;
          if (cnt_us_q == 8'd84) begin
            rx_data_d = byte_q;
            cnt_us_d  = 8'd0;
            if (maj) begin
              rx_vld_d = 1'b1;
              state_d  = IDLE;
            end else begin
              rx_err_d = 1'b1;
              state_d  = WAIT_HIGH;
            end
          end
        end
      end
      WAIT_HIGH: begin
        // A break or stuck-low line must go high before a new start edge can count.
        cnt_us_d = 8'd0;
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      cnt_us_q  <= 8'd0;
      maj_sh_q  <= 3'b111;
      byte_q    <= 8'h00;
      bit_idx_q <= 3'd0;
      rx_data_q <= 8'h00;
      rx_vld_q  <= 1'b0;
      rx_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      rx_s_q    <= rx_s_d;
      rx_prev_q <= rx_prev_d;
      cnt_us_q  <= cnt_us_d;
      maj_sh_q  <= maj_sh_d;
      byte_q    <= byte_d;
      bit_idx_q <= bit_idx_d;
      rx_data_q <= rx_data_d;
      rx_vld_q  <= rx_vld_d;
      rx_err_q  <= rx_err_d;
    end
  end

  assign rx_data = rx_data_q;
  assign rx_vld  = rx_vld_q;
  assign rx_err  = rx_err_q;

endmodule
